// File: rtl/note_sequencer.sv
// Note-table sequencer: plays programmed entries at a set tempo,
// driving the counter phase step, waveform select and gate.
module note_sequencer #(
  parameter int NOTES   = 8,
  parameter int ADDER_W = 16,
  parameter int UNIT    = 64,
  parameter int TEMPO_W = 16,
  localparam int AW     = $clog2(NOTES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [3:0]         wr_note,
  input  logic [3:0]         wr_len,
  input  logic [2:0]         wr_wave,
  output logic [ADDER_W-1:0] adder,
  output logic [2:0]         wave_sel,
  output logic               gate,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      pos
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]         r_note [NOTES];
  logic [3:0]         r_len  [NOTES];
  logic [2:0]         r_wave [NOTES];

  logic [ADDER_W-1:0] r_adder;
  logic [2:0]         r_wsel;
  logic               r_gate;
  logic               r_busy;
  logic               r_done;
  logic [AW-1:0]      r_pos;
  logic [TEMPO_W-1:0] r_tick;
  logic [3:0]         r_beat;

  logic [ADDER_W-1:0] w_adder;
  logic [2:0]         w_wsel;
  logic               w_gate;
  logic               w_done;
  logic [AW-1:0]      w_pos;
  logic [TEMPO_W-1:0] w_tick;
  logic [3:0]         w_beat;

  logic [3:0]         w_note;
  logic [3:0]         w_len;
  logic [2:0]         w_ewave;
  logic [ADDER_W-1:0] w_step;
  logic [TEMPO_W-1:0] w_tlast;
  logic               w_tend;
  logic               w_lastpos;

  assign w_note    = r_note[r_pos];
  assign w_len     = r_len[r_pos];
  assign w_ewave   = r_wave[r_pos];
  assign w_step    = ADDER_W'(w_note) * ADDER_W'(UNIT);
  assign w_tlast   = (tempo == '0) ? '0 : tempo - 1'b1;
  // >= keeps a beat from overrunning when tempo drops mid-beat
  assign w_tend    = (r_tick >= w_tlast);
  assign w_lastpos = (r_pos == AW'(NOTES - 1));

  always_comb begin
    w_next  = r_state;
    w_adder = r_adder;
    w_wsel  = r_wsel;
    w_gate  = r_gate;
    w_done  = 1'b0;
    w_pos   = r_pos;
    w_tick  = r_tick;
    w_beat  = r_beat;
    unique case (r_state)
      S_IDLE: begin
        w_adder = '0;
        w_gate  = 1'b0;
        if (start && !stop) begin
          w_next = S_LOAD;
          w_pos  = '0;
        end
      end
      S_LOAD: begin
        w_gate = 1'b0;
        if (w_len == 4'd0) begin
          if (r_pos != '0 && loop) begin
            w_pos = '0;
          end else begin
            w_next  = S_DONE;
            w_done  = 1'b1;
            w_adder = '0;
          end
        end else begin
          w_next  = S_PLAY;
          w_adder = w_step;
          w_wsel  = w_ewave;
          w_gate  = (w_note != 4'd0);
          w_beat  = w_len;
          w_tick  = '0;
        end
      end
      S_PLAY: begin
        if (w_tend) begin
          w_tick = '0;
          w_beat = r_beat - 4'd1;
          if (r_beat == 4'd1) begin
            w_gate = 1'b0;
            if (!w_lastpos) begin
              w_pos  = r_pos + 1'b1;
              w_next = S_LOAD;
            end else if (loop) begin
              w_pos  = '0;
              w_next = S_LOAD;
            end else begin
              w_next  = S_DONE;
              w_done  = 1'b1;
              w_adder = '0;
            end
          end
        end else begin
          w_tick = r_tick + 1'b1;
        end
      end
      S_DONE: begin
        w_next  = S_IDLE;
        w_adder = '0;
        w_gate  = 1'b0;
      end
    endcase
    if (stop && r_state != S_IDLE) begin
      w_next  = S_IDLE;
      w_adder = '0;
      w_gate  = 1'b0;
      w_pos   = '0;
      w_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_adder <= '0;
      r_wsel  <= '0;
      r_gate  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pos   <= '0;
      r_tick  <= '0;
      r_beat  <= '0;
      for (int i = 0; i < NOTES; i++) begin
        r_note[i] <= '0;
        r_len[i]  <= '0;
        r_wave[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_adder <= w_adder;
      r_wsel  <= w_wsel;
      r_gate  <= w_gate;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= w_done;
      r_pos   <= w_pos;
      r_tick  <= w_tick;
      r_beat  <= w_beat;
      if (wr_en && !r_busy) begin
        r_note[wr_addr] <= wr_note;
        r_len[wr_addr]  <= wr_len;
        r_wave[wr_addr] <= wr_wave;
      end
    end
  end

  assign adder    = r_adder;
  assign wave_sel = r_wsel;
  assign gate     = r_gate;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pos      = r_pos;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random tables,
// checked cycle by cycle against a timeline built from the table.
module tb_note_sequencer;

  localparam int NOTES = 8;
  localparam int UNIT  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        loop;
  logic [15:0] tempo;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_note;
  logic [3:0]  wr_len;
  logic [2:0]  wr_wave;
  logic [15:0] adder;
  logic [2:0]  wave_sel;
  logic        gate;
  logic        busy;
  logic        done;
  logic [2:0]  pos;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  note_sequencer #(
    .NOTES(8), .ADDER_W(16), .UNIT(64), .TEMPO_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .loop(loop), .tempo(tempo), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_note(wr_note), .wr_len(wr_len),
    .wr_wave(wr_wave), .adder(adder), .wave_sel(wave_sel),
    .gate(gate), .busy(busy), .done(done), .pos(pos)
  );

  typedef struct {
    int adder;
    int wave;
    int gate;
    int busy;
    int done;
    int pos;
    bit chk_pw;
  } exp_t;

  exp_t eq[$];
  bit   m_ended;
  int   m_note[NOTES];
  int   m_len[NOTES];
  int   m_wave[NOTES];
  int   m_ws;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic clear_mirror();
    for (int i = 0; i < NOTES; i++) begin
      m_note[i] = 0;
      m_len[i]  = 0;
      m_wave[i] = 0;
    end
    m_ws = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
    clear_mirror();
  endtask

  task automatic wr(input int a, input int n, input int l, input int w);
    wr_en   = 1'b1;
    wr_addr = a[2:0];
    wr_note = n[3:0];
    wr_len  = l[3:0];
    wr_wave = w[2:0];
    step();
    wr_en   = 1'b0;
    m_note[a] = n;
    m_len[a]  = l;
    m_wave[a] = w;
  endtask

  // Expected per-cycle timeline from the first LOAD onward
  task automatic build(input bit lp, input int t, input int maxc);
    int p  = 0;
    int a  = 0;
    int w  = m_ws;
    int te = (t == 0) ? 1 : t;
    eq.delete();
    m_ended = 1'b0;
    while (eq.size() < maxc) begin
      eq.push_back('{a, w, 0, 1, 0, p, 1'b1});
      if (m_len[p] == 0) begin
        if (p != 0 && lp) begin
          p = 0;
          continue;
        end
        m_ended = 1'b1;
        break;
      end
      a = (m_note[p] * UNIT) % 65536;
      w = m_wave[p];
      repeat (m_len[p] * te)
        eq.push_back('{a, w, int'(m_note[p] != 0), 1, 0, p, 1'b1});
      if (p == NOTES - 1) begin
        if (lp) p = 0;
        else begin
          m_ended = 1'b1;
          break;
        end
      end else begin
        p++;
      end
    end
    if (m_ended) begin
      eq.push_back('{0, w, 0, 1, 1, p, 1'b0});
      eq.push_back('{0, w, 0, 0, 0, p, 1'b0});
    end
  endtask

  task automatic play(input string tg, input bit lp, input int t,
                      input int maxc, input int wr_at);
    build(lp, t, maxc);
    loop  = lp;
    tempo = t[15:0];
    start = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    foreach (eq[i]) begin
      chk({tg, ".adder"}, adder, eq[i].adder);
      chk({tg, ".gate"}, gate, eq[i].gate);
      chk({tg, ".busy"}, busy, eq[i].busy);
      chk({tg, ".done"}, done, eq[i].done);
      if (eq[i].chk_pw) begin
        chk({tg, ".pos"}, pos, eq[i].pos);
        chk({tg, ".wave"}, wave_sel, eq[i].wave);
      end
      if (i != eq.size() - 1) begin
        if (i == wr_at) begin
          wr_en   = 1'b1;
          wr_addr = 3'd0;
          wr_note = 4'd9;
          wr_len  = 4'd2;
          wr_wave = 3'd7;
        end
        step();
        wr_en = 1'b0;
      end
    end
    m_ws = eq[eq.size() - 1].wave;
    if (!m_ended) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk({tg, ".stop_busy"}, busy, 0);
      chk({tg, ".stop_adder"}, adder, 0);
      chk({tg, ".stop_gate"}, gate, 0);
      chk({tg, ".stop_pos"}, pos, 0);
      chk({tg, ".stop_done"}, done, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    tempo = 16'd4; wr_en = 1'b0; wr_addr = '0;
    wr_note = '0; wr_len = '0; wr_wave = '0;
    #2;
    do_reset(3);
    chk("rst.adder", adder, 0);
    chk("rst.wave", wave_sel, 0);
    chk("rst.gate", gate, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pos", pos, 0);

    play("empty", 1'b1, 4, 50, -1);

    wr(0, 3, 2, 1);
    wr(1, 0, 1, 0);
    wr(2, 0, 0, 0);
    play("tl", 1'b0, 4, 100, -1);
    play("tl_loop", 1'b1, 4, 40, -1);
    repeat (3) begin
      step();
      chk("stop.no_done", done, 0);
      chk("stop.idle", busy, 0);
    end

    play("busy_wr", 1'b1, 4, 20, 3);
    play("replay", 1'b0, 4, 100, -1);

    for (int k = 0; k < NOTES; k++) wr(k, k + 1, 1, k);
    play("all8", 1'b0, 0, 100, -1);
    play("all8_loop", 1'b1, 0, 30, -1);

    // reset while a note is sounding
    wr(0, 5, 2, 3);
    tempo = 16'd4; loop = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("mid.gate", gate, 1);
    reset = 1'b1; step(); reset = 1'b0;
    clear_mirror();
    chk("mrst.adder", adder, 0);
    chk("mrst.wave", wave_sel, 0);
    chk("mrst.gate", gate, 0);
    chk("mrst.busy", busy, 0);
    chk("mrst.done", done, 0);
    chk("mrst.pos", pos, 0);
    play("after_rst", 1'b0, 4, 20, -1);

    start = 1'b1; stop = 1'b1; step();
    chk("ss.busy0", busy, 0);
    start = 1'b0; stop = 1'b0; step();
    chk("ss.busy1", busy, 0);

    // tempo 4 -> 2 during a 3-beat note
    wr(0, 5, 3, 2);
    tempo = 16'd4; loop = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("tch.load_gate", gate, 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 5) tempo = 16'd2;
      chk("tch.gate", gate, 1);
      chk("tch.adder", adder, 320);
    end
    step();
    chk("tch.load2_gate", gate, 0);
    chk("tch.load2_busy", busy, 1);
    chk("tch.load2_pos", pos, 1);
    step();
    chk("tch.done", done, 1);
    step();
    chk("tch.idle", busy, 0);
    m_ws = 2;

    // write to entry 0 in the same cycle as start
    wr_en = 1'b1; wr_addr = 3'd0; wr_note = 4'd7;
    wr_len = 4'd1; wr_wave = 3'd5;
    m_note[0] = 7; m_len[0] = 1; m_wave[0] = 5;
    play("wr_start", 1'b0, 3, 100, -1);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NOTES; k++) begin
        int ln;
        ln = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3);
        wr(k, $urandom_range(0, 15), ln, $urandom_range(0, 7));
      end
      play("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           120, -1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
